// File: rtl/chaos_pkg.sv
// ---------------------------------------------------------------------------
// chaos_pkg
// Shared definitions for the common-data-bus arbiter: bus widths, the
// reserved "free" ROB tag, source identifiers and a grant-to-source helper.
// ---------------------------------------------------------------------------
package chaos_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int SRC_W  = 2;
  localparam int N_REQ  = 3;

  // Tag value that never names a live ROB entry; seeing it on a request
  // points at a bookkeeping bug upstream.
  localparam logic [TAG_W-1:0] TAG_FREE = 4'hF;

  typedef enum logic [SRC_W-1:0] {
    SRC_ALU = 2'd0,
    SRC_BR  = 2'd1,
    SRC_LS  = 2'd2
  } cdb_src_e;

  // Last-grant value after reset: ALU is the first requester in the order.
  localparam cdb_src_e PTR_RESET = SRC_LS;

  // Map a one-hot grant vector (bit 0 = ALU, 1 = branch, 2 = LSBuf) to the
  // source ID broadcast on the CDB. An all-zero vector maps to SRC_ALU;
  // callers only use the result when a grant is present.
  function automatic logic [SRC_W-1:0] onehot_to_src(input logic [N_REQ-1:0] gnt);
    logic [SRC_W-1:0] src;
    src = SRC_ALU;
    if (gnt[2]) begin
      src = SRC_LS;
    end else if (gnt[1]) begin
      src = SRC_BR;
    end
    return src;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// ---------------------------------------------------------------------------
// rr_arbiter3
// Pure combinational three-way grant selection.
//   FIXED_PRIO = 0 : round robin; search starts at the requester after ptr
//                    and wraps from 2 to 0.
//   FIXED_PRIO = 1 : fixed priority req[2] > req[1] > req[0]; ptr ignored.
// Ports:
//   req [2:0]  in   request vector (bit 0 = ALU, 1 = branch, 2 = LSBuf)
//   ptr [1:0]  in   last-grant pointer (0, 1 or 2)
//   gnt [2:0]  out  one-hot grant, subset of req; zero when req is zero
// ---------------------------------------------------------------------------
module rr_arbiter3 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = 3'b000;
    if (FIXED_PRIO) begin
      if (req[2]) begin
        gnt = 3'b100;
      end else if (req[1]) begin
        gnt = 3'b010;
      end else if (req[0]) begin
        gnt = 3'b001;
      end
    end else begin
      case (ptr)
        2'd0: begin
          // order: branch, LSBuf, ALU
          if (req[1]) begin
            gnt = 3'b010;
          end else if (req[2]) begin
            gnt = 3'b100;
          end else if (req[0]) begin
            gnt = 3'b001;
          end
        end
        2'd1: begin
          // order: LSBuf, ALU, branch
          if (req[2]) begin
            gnt = 3'b100;
          end else if (req[0]) begin
            gnt = 3'b001;
          end else if (req[1]) begin
            gnt = 3'b010;
          end
        end
        default: begin
          // ptr == 2 (and the unreachable 3): ALU, branch, LSBuf
          if (req[0]) begin
            gnt = 3'b001;
          end else if (req[1]) begin
            gnt = 3'b010;
          end else if (req[2]) begin
            gnt = 3'b100;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Arbitrates the ALU, branch unit and load/store buffer onto the single
// common data bus. Readies are a combinational grant; the winning result is
// registered and broadcast one cycle later to the ROB and reservation
// stations.
//
// Build option: CDB_ARB_ROUND_ROBIN_EN
//   defined   : round robin on a 2-bit last-grant pointer (reset value 2,
//               so ALU wins first), updated only on a transfer.
//   undefined : fixed priority LSBuf > branch > ALU, no pointer register.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   <req>_valid/_tag/_data   result offered by requester (alu, br, ls)
//   <req>_ready              grant; transfer when valid & ready
//   flush                    synchronous mispredict flush, blocks all grants
//   cdb_valid/_tag/_data     registered broadcast
//   cdb_src                  0 = ALU, 1 = branch, 2 = LSBuf
//   err_free_tag             sticky: a transfer carried TAG_FREE
// ---------------------------------------------------------------------------
module cdb_arbiter
  import chaos_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              br_valid,
  input  logic [TAG_W-1:0]  br_tag,
  input  logic [DATA_W-1:0] br_data,
  output logic              br_ready,
  input  logic              ls_valid,
  input  logic [TAG_W-1:0]  ls_tag,
  input  logic [DATA_W-1:0] ls_data,
  output logic              ls_ready,
  input  logic              flush,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic [SRC_W-1:0]  cdb_src,
  output logic              err_free_tag
);

  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  gnt;
  logic [1:0]        ptr;
  logic              xfer;
  logic [SRC_W-1:0]  sel_src;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;

  // Requests are masked before arbitration, so a flush or an asserted reset
  // yields no grant at all rather than a grant that is later discarded.
  assign req = {ls_valid, br_valid, alu_valid} & {N_REQ{~flush & rst}};

`ifdef CDB_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= PTR_RESET;
    end else if (xfer) begin
      ptr <= sel_src;
    end
  end

  rr_arbiter3 #(
    .FIXED_PRIO (1'b0)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt)
  );
`else
  assign ptr = PTR_RESET;

  rr_arbiter3 #(
    .FIXED_PRIO (1'b1)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt)
  );
`endif

  assign alu_ready = gnt[0];
  assign br_ready  = gnt[1];
  assign ls_ready  = gnt[2];
  assign xfer      = |gnt;
  assign sel_src   = onehot_to_src(gnt);

  always_comb begin
    sel_tag  = alu_tag;
    sel_data = alu_data;
    case (gnt)
      3'b010: begin
        sel_tag  = br_tag;
        sel_data = br_data;
      end
      3'b100: begin
        sel_tag  = ls_tag;
        sel_data = ls_data;
      end
      default: begin
        sel_tag  = alu_tag;
        sel_data = alu_data;
      end
    endcase
  end

  // Payload holds its last value when nothing is broadcast.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else begin
      cdb_valid <= xfer;
      if (xfer) begin
        cdb_tag  <= sel_tag;
        cdb_data <= sel_data;
        cdb_src  <= sel_src;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_free_tag <= 1'b0;
    end else if (xfer && (sel_tag == TAG_FREE)) begin
      err_free_tag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import chaos_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [2:0]        vld;
  logic [TAG_W-1:0]  tg [3];
  logic [DATA_W-1:0] dt [3];
  logic              alu_rdy, br_rdy, ls_rdy;
  logic [2:0]        rdy;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [1:0]        cdb_src;
  logic              err_free_tag;

  assign rdy = {ls_rdy, br_rdy, alu_rdy};

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (vld[0]),
    .alu_tag      (tg[0]),
    .alu_data     (dt[0]),
    .alu_ready    (alu_rdy),
    .br_valid     (vld[1]),
    .br_tag       (tg[1]),
    .br_data      (dt[1]),
    .br_ready     (br_rdy),
    .ls_valid     (vld[2]),
    .ls_tag       (tg[2]),
    .ls_data      (dt[2]),
    .ls_ready     (ls_rdy),
    .flush        (flush),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_src      (cdb_src),
    .err_free_tag (err_free_tag)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: last granted requester, expected bus contents, sticky error.
  int                m_last;
  logic              m_valid;
  logic [TAG_W-1:0]  m_tag;
  logic [DATA_W-1:0] m_data;
  int                m_src;
  logic              m_err;
  logic [2:0]        eg;

  task automatic model_reset();
    m_last  = 2;
    m_valid = 1'b0;
    m_tag   = '0;
    m_data  = '0;
    m_src   = 0;
    m_err   = 1'b0;
  endtask

  // Which requester should be granted right now, as a one-hot vector.
  function automatic logic [2:0] exp_rdy();
    logic [2:0] r;
    int i;
    r = 3'b000;
    if (rst !== 1'b1 || flush || vld == 3'b000) return r;
`ifdef CDB_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) begin
      i = (m_last + k) % 3;
      if (vld[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
`else
    for (int k = 2; k >= 0; k--) begin
      if (vld[k]) begin
        r[k] = 1'b1;
        return r;
      end
    end
`endif
    return r;
  endfunction

  // Advance one clock edge and update the model; ends at posedge + 1.
  task automatic tick();
    int idx;
    eg = exp_rdy();
    @(posedge clk);
    if (eg != 3'b000) begin
      idx     = eg[2] ? 2 : (eg[1] ? 1 : 0);
      m_valid = 1'b1;
      m_tag   = tg[idx];
      m_data  = dt[idx];
      m_src   = idx;
      m_last  = idx;
      if (tg[idx] == TAG_FREE) m_err = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic new_payload(input int i);
    tg[i] = TAG_W'($urandom_range(0, 14));
    dt[i] = $urandom;
  endtask

  task automatic apply_reset();
    rst   = 1'b0;
    vld   = 3'b000;
    flush = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    flush = 1'b0;
    vld   = 3'b111;
    for (int i = 0; i < 3; i++) new_payload(i);
    #12;
    n_cmp++; if (rdy !== 3'b000) begin n_bad++; $display("FAIL reset_ready got=%b want=000", rdy); end
    n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cdb_valid got=%b want=0", cdb_valid); end
    n_cmp++; if (cdb_tag !== '0 || cdb_data !== '0 || cdb_src !== 2'd0) begin
      n_bad++; $display("FAIL reset_payload got tag=%h data=%h src=%0d want 0/0/0", cdb_tag, cdb_data, cdb_src);
    end
    n_cmp++; if (err_free_tag !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err_free_tag); end
    vld = 3'b000;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_first_grant();
    vld   = 3'b001;
    tg[0] = 4'd3;
    dt[0] = 32'h11;
    #1;
    n_cmp++; if (rdy !== 3'b001) begin n_bad++; $display("FAIL first_ready got=%b want=001", rdy); end
    tick();
    n_cmp++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd3 || cdb_data !== 32'h11 || cdb_src !== 2'd0) begin
      n_bad++; $display("FAIL first_bcast got v=%b tag=%0d data=%h src=%0d want 1/3/11/0", cdb_valid, cdb_tag, cdb_data, cdb_src);
    end
    vld = 3'b000;
    tick();
    n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL first_idle got=%b want=0", cdb_valid); end
    n_cmp++; if (cdb_tag !== 4'd3 || cdb_data !== 32'h11) begin
      n_bad++; $display("FAIL first_hold got tag=%0d data=%h want 3/11", cdb_tag, cdb_data);
    end
  endtask

  task automatic test_all_three();
    int exp_seq [6];
`ifdef CDB_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 2, 0, 1, 2};
`else
    exp_seq = '{2, 2, 2, 2, 2, 2};
`endif
    apply_reset();
    vld = 3'b111;
    for (int i = 0; i < 3; i++) new_payload(i);
    for (int c = 0; c < 6; c++) begin
      #1;
      n_cmp++; if ($countones(rdy) != 1) begin n_bad++; $display("FAIL all3_onehot c=%0d got=%b want one-hot", c, rdy); end
      n_cmp++; if (rdy !== (3'b001 << exp_seq[c])) begin
        n_bad++; $display("FAIL all3_grant c=%0d got=%b want src %0d", c, rdy, exp_seq[c]);
      end
      tick();
      n_cmp++; if (cdb_valid !== 1'b1 || cdb_src !== 2'(exp_seq[c]) || cdb_tag !== m_tag || cdb_data !== m_data) begin
        n_bad++; $display("FAIL all3_bcast c=%0d got v=%b src=%0d tag=%0d data=%h want 1/%0d/%0d/%h",
                          c, cdb_valid, cdb_src, cdb_tag, cdb_data, exp_seq[c], m_tag, m_data);
      end
      new_payload(exp_seq[c]);
    end
    vld = 3'b000;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d;
    vld = 3'b010;
    for (int i = 1; i <= 4; i++) begin
      tg[1] = TAG_W'(i);
      d     = $urandom;
      dt[1] = d;
      #1;
      n_cmp++; if (rdy !== 3'b010) begin n_bad++; $display("FAIL b2b_ready i=%0d got=%b want=010", i, rdy); end
      tick();
      n_cmp++; if (cdb_valid !== 1'b1 || cdb_tag !== TAG_W'(i) || cdb_data !== d || cdb_src !== 2'd1) begin
        n_bad++; $display("FAIL b2b_bcast i=%0d got v=%b tag=%0d data=%h src=%0d want 1/%0d/%h/1",
                          i, cdb_valid, cdb_tag, cdb_data, cdb_src, i, d);
      end
    end
    vld = 3'b000;
    tick();
    n_cmp++; if (cdb_valid !== 1'b0 || cdb_tag !== 4'd4) begin
      n_bad++; $display("FAIL b2b_idle got v=%b tag=%0d want 0/4", cdb_valid, cdb_tag);
    end
  endtask

  task automatic test_flush();
    logic [2:0] want;
    logic [TAG_W-1:0] held;
    vld = 3'b001;
    new_payload(0);
    held = tg[0];
    #1;
    tick();
    n_cmp++; if (cdb_valid !== 1'b1) begin n_bad++; $display("FAIL flush_pre got=%b want=1", cdb_valid); end
    vld   = 3'b100;
    flush = 1'b1;
    new_payload(2);
    #1;
    n_cmp++; if (ls_rdy !== 1'b0 || rdy !== 3'b000) begin n_bad++; $display("FAIL flush_ready got=%b want=000", rdy); end
    tick();
    n_cmp++; if (cdb_valid !== 1'b0 || cdb_tag !== held) begin
      n_bad++; $display("FAIL flush_bcast got v=%b tag=%0d want 0/%0d", cdb_valid, cdb_tag, held);
    end
    flush = 1'b0;
    vld   = 3'b111;
    for (int i = 0; i < 3; i++) new_payload(i);
`ifdef CDB_ARB_ROUND_ROBIN_EN
    want = 3'b010;
`else
    want = 3'b100;
`endif
    #1;
    n_cmp++; if (rdy !== want || rdy !== exp_rdy()) begin
      n_bad++; $display("FAIL flush_ptr got=%b want=%b", rdy, want);
    end
    tick();
    n_cmp++; if (cdb_valid !== 1'b1 || cdb_src !== 2'(m_src)) begin
      n_bad++; $display("FAIL flush_after got v=%b src=%0d want 1/%0d", cdb_valid, cdb_src, m_src);
    end
    vld = 3'b000;
    tick();
  endtask

  task automatic test_free_tag();
    vld   = 3'b001;
    tg[0] = TAG_FREE;
    dt[0] = 32'hDEAD_BEEF;
    #1;
    tick();
    n_cmp++; if (cdb_valid !== 1'b1 || cdb_tag !== TAG_FREE || cdb_data !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL free_bcast got v=%b tag=%h data=%h want 1/%h/deadbeef", cdb_valid, cdb_tag, cdb_data, TAG_FREE);
    end
    n_cmp++; if (err_free_tag !== 1'b1) begin n_bad++; $display("FAIL free_err_set got=%b want=1", err_free_tag); end
    vld = 3'b000;
    repeat (3) tick();
    n_cmp++; if (err_free_tag !== 1'b1) begin n_bad++; $display("FAIL free_err_sticky got=%b want=1", err_free_tag); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (err_free_tag !== 1'b0) begin n_bad++; $display("FAIL free_err_clear got=%b want=0", err_free_tag); end
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_async_reset();
    vld = 3'b010;
    new_payload(1);
    #1;
    tick();
    n_cmp++; if (cdb_valid !== 1'b1) begin n_bad++; $display("FAIL arst_pre got=%b want=1", cdb_valid); end
    new_payload(1);
    #2;
    n_cmp++; if (br_rdy !== 1'b1) begin n_bad++; $display("FAIL arst_ready_pre got=%b want=1", br_rdy); end
    rst = 1'b0;
    #1;
    n_cmp++; if (cdb_valid !== 1'b0) begin n_bad++; $display("FAIL arst_drop got=%b want=0", cdb_valid); end
    n_cmp++; if (rdy !== 3'b000) begin n_bad++; $display("FAIL arst_ready got=%b want=000", rdy); end
    @(posedge clk);
    #1;
    model_reset();
    vld = 3'b000;
    rst = 1'b1;
    tick();
    n_cmp++; if (cdb_valid !== 1'b0 || cdb_tag !== '0) begin
      n_bad++; $display("FAIL arst_after got v=%b tag=%0d want 0/0", cdb_valid, cdb_tag);
    end
  endtask

  task automatic test_random();
    logic [2:0] g_prev;
    logic       f_prev;
    apply_reset();
    g_prev = 3'b000;
    f_prev = 1'b0;
    for (int c = 0; c < 400; c++) begin
      // A requester keeps its result until granted; a flush discards it.
      for (int i = 0; i < 3; i++) begin
        if (!vld[i] || g_prev[i] || f_prev) begin
          vld[i] = ($urandom_range(0, 2) != 0);
          new_payload(i);
        end
      end
      flush = ($urandom_range(0, 9) == 0);
      #1;
      n_cmp++; if (rdy !== exp_rdy()) begin
        n_bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b vld=%b flush=%b", c, rdy, exp_rdy(), vld, flush);
      end
      n_cmp++; if ($countones(rdy) > 1) begin n_bad++; $display("FAIL rnd_onehot c=%0d got=%b want at most one", c, rdy); end
      f_prev = flush;
      tick();
      g_prev = eg;
      n_cmp++; if (cdb_valid !== m_valid) begin
        n_bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, cdb_valid, m_valid);
      end
      n_cmp++; if (cdb_tag !== m_tag || cdb_data !== m_data || cdb_src !== 2'(m_src)) begin
        n_bad++; $display("FAIL rnd_payload c=%0d got tag=%0d data=%h src=%0d want %0d/%h/%0d",
                          c, cdb_tag, cdb_data, cdb_src, m_tag, m_data, m_src);
      end
      n_cmp++; if (err_free_tag !== m_err) begin
        n_bad++; $display("FAIL rnd_err c=%0d got=%b want=%b", c, err_free_tag, m_err);
      end
    end
    vld   = 3'b000;
    flush = 1'b0;
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_grant();
    test_all_three();
    test_back_to_back();
    test_flush();
    test_free_tag();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
